instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter MAX_OUTSTANDING, 2, limit on in-flight imem requests plus buffered instructions.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_addr  output  32  word-aligned fetch address.
REQ-007 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-008 imem_rsp_valid  input  1  in-order response valid; no backpressure.
REQ-009 imem_rsp_data  input  32  instruction word.
REQ-010 redirect  input  1  taken branch, JAL or JALR (pc_src != 00 and taken).
REQ-011 redirect_pc  input  32  new fetch target.
REQ-012 instr_valid  output  1  buffer head holds a valid instruction.
REQ-013 instr_ready  input  1  decode/control consumes the head this cycle.
REQ-014 instr  output  32  head instruction word.
REQ-015 instr_pc  output  32  PC of the head instruction.
REQ-016 opcode/funct3/funct7  output  7/3/7  head instr[6:0], [14:12], [31:25].

Function
REQ-017 A request handshake occurs when imem_req_valid and imem_req_ready are both 1; fetch_pc then advances by 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-018 imem_req_valid SHALL be 1 only in RUN and only when outstanding + occupancy < MAX_OUTSTANDING.
REQ-019 imem_req_valid and imem_req_addr SHALL remain stable until accepted, unless a redirect occurs.
REQ-020 In RUN, each response SHALL be written to a 2-entry FIFO together with its request PC; the response arrives no earlier than the cycle after acceptance.
REQ-021 A response in the same cycle as a head pop SHALL be legal; the FIFO SHALL never overflow because of REQ-018.
REQ-022 Consume: a head pop occurs when instr_valid and instr_ready are both 1; the next entry is presented in the following cycle.
REQ-023 FSM states: RUN, FLUSH.
REQ-024 Redirect in RUN: on the next edge, clear the FIFO, set fetch_pc to {redirect_pc[31:2],2'b00}, and enter FLUSH if outstanding > 0, else stay in RUN.
REQ-025 FLUSH: no requests are issued; each response decrements outstanding and is discarded; leave for RUN on the edge where outstanding reaches 0.
REQ-026 Redirect while in FLUSH: update fetch_pc; the state stays FLUSH.
REQ-027 Redirect in the same cycle as a request handshake: that request is counted as outstanding and its response is discarded.
REQ-028 Redirect in the same cycle as a response: the response is discarded and outstanding decrements.
REQ-029 Redirect in the same cycle as a head pop: the pop completes, then the FIFO is cleared.
REQ-030 Best-case latency from redirect to instr_valid: 2 cycles when outstanding = 0 and imem responds the cycle after acceptance.

Reset
REQ-031 rst SHALL set fetch_pc = RESET_PC, state = RUN, outstanding = 0, FIFO empty.
REQ-032 During and after reset: imem_req_valid = 0, instr_valid = 0, instr/instr_pc/opcode/funct3/funct7 = 0.
REQ-033 The first request SHALL be raised in the cycle after rst deasserts.
REQ-034 Responses to requests issued before a mid-operation reset are ignored; memory is reset concurrently.

Structure
REQ-035 Package riscv_pkg SHALL hold the opcode localparams shared with control_unit, the pc_src encodings, and the RESET_PC default.
REQ-036 One sub-module, fetch_fifo: 2-entry {pc, instr} FIFO with push/pop/flush/count.

Verification
REQ-037 Reset, then stream: imem always ready, 1-cycle latency, instr_ready = 1 -> requests at 0,4,8,... and instr_pc 0,4,8 in order; first instr_valid 2 cycles after reset release.
REQ-038 instr_ready = 0 for 10 cycles -> at most 2 requests outstanding/buffered; no word lost or duplicated after release.
REQ-039 Redirect to 32'h100 with 2 outstanding -> both responses discarded, state FLUSH, next request addr 32'h100, first instr_pc 32'h100.
REQ-040 Redirect to 32'h203 -> fetch addr 32'h200.
REQ-041 fetch_pc 32'hFFFF_FFFC -> next request addr 32'h0.
REQ-042 rst asserted mid-stream with pending response -> all outputs 0 next cycle; restart at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: opcodes, pc_src encodings, fetch types.
// Used by instr_fetch, fetch_fifo and control_unit.
package riscv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JAL    = 2'b10;
  localparam logic [1:0] PC_SRC_JALR   = 2'b11;

  typedef enum logic {
    FS_RUN   = 1'b0,
    FS_FLUSH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small {pc, instr} buffer between imem responses and decode.
// Flush and reset empty it; a pop on a flush cycle is simply absorbed.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;
  logic          clr;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign clr     = rst || flush;
  assign do_pop  = pop && (cnt_q != '0);
  assign do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= nxt(wr_q);
      if (do_pop)  rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_q] <= push_data;
  end

  assign head  = mem[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues word fetches, buffers responses with their PC,
// and drops in-flight responses after a redirect.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   in_use;
  logic          req_hs;
  logic          rsp_take;
  logic          push;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  assign in_use = {1'b0, out_q} + {1'b0, fifo_count};

  assign imem_req_valid = !rst && (state_q == FS_RUN)
                       && (in_use < (CW + 1)'(MAX_OUTSTANDING));
  assign imem_req_addr  = fetch_pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;
  assign rsp_take       = imem_rsp_valid && (out_q != '0);

  // Responses in RUN belong to consecutive requests ending at fetch_pc.
  assign push             = (state_q == FS_RUN) && rsp_take && !redirect;
  assign push_entry.pc    = fetch_pc_q - (32'(out_q) << 2);
  assign push_entry.instr = imem_rsp_data;

  assign instr_valid = !rst && (fifo_count != '0);
  assign pop         = instr_valid && instr_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = req_hs ? fetch_pc_q + 32'd4 : fetch_pc_q;
    out_d      = out_q + CW'(req_hs) - CW'(rsp_take);
    unique case (state_q)
      FS_RUN: begin
        if (redirect) begin
          fetch_pc_d = word_align(redirect_pc);
          if (out_d != '0) state_d = FS_FLUSH;
        end
      end
      FS_FLUSH: begin
        if (redirect) fetch_pc_d = word_align(redirect_pc);
        if (out_d == '0) state_d = FS_RUN;
      end
      default: state_d = FS_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FS_RUN;
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
    end
  end

  fetch_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (fifo_count)
  );

  assign instr    = instr_valid ? head.instr : '0;
  assign instr_pc = instr_valid ? head.pc    : '0;
  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a queued in-order imem model.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] reqs[$];
  logic [63:0] popped[$];
  logic [31:0] mq[$];
  logic        mem_hold;

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: log handshakes, advance, then drive the memory response.
  task automatic cycle();
    if (instr_valid && instr_ready) popped.push_back({instr_pc, instr});
    if (imem_req_valid && imem_req_ready) begin
      reqs.push_back(imem_req_addr);
      mq.push_back(imem_req_addr);
    end
    if (imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
    @(posedge clk);
    @(negedge clk);
    if (rst) mq.delete();
    if (mq.size() > 0 && !mem_hold) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_at(mq[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    cycle();
    redirect    = 1'b0;
    redirect_pc = '0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rv"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_iv"}, 32'(instr_valid), 32'd0);
    check({tag, "_ins"}, instr, 32'd0);
    check({tag, "_pc"}, instr_pc, 32'd0);
    check({tag, "_fld"}, {15'd0, funct7, funct3, opcode}, 32'd0);
  endtask

  initial begin
    int pidx;
    int ridx;
    int n_stream;
    bit found;
    logic [31:0] w;

    rst            = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    mem_hold       = 1'b0;

    cycles(3);
    check_zero("reset");

    // Release reset and stream.
    rst = 1'b0;
    #1;
    check("first_req_v", 32'(imem_req_valid), 32'd1);
    check("first_req_a", imem_req_addr, 32'h0);
    cycle();
    check("lat_c1", 32'(instr_valid), 32'd0);
    cycle();
    check("lat_c2", 32'(instr_valid), 32'd1);
    check("lat_pc", instr_pc, 32'h0);
    check("lat_ins", instr, word_at(32'h0));
    cycles(12);
    for (int i = 0; i < 4; i++)
      check("stream_addr", reqs[i], 32'(i * 4));

    // Backpressure.
    instr_ready = 1'b0;
    cycles(10);
    check("bp_inflight", 32'(reqs.size() - popped.size()), 32'd2);
    check("bp_noreq", 32'(imem_req_valid), 32'd0);
    check("bp_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    cycles(10);
    n_stream = popped.size();
    check("bp_npop", 32'(n_stream >= 8), 32'd1);
    for (int i = 0; i < n_stream; i++) begin
      check("seq_pc", popped[i][63:32], 32'(i * 4));
      check("seq_ins", popped[i][31:0], word_at(32'(i * 4)));
    end

    // Redirect with two requests in flight.
    mem_hold = 1'b1;
    cycles(6);
    check("hold_noreq", 32'(imem_req_valid), 32'd0);
    check("hold_empty", 32'(instr_valid), 32'd0);
    do_redirect(32'h100);
    pidx = popped.size();
    check("flush_noreq0", 32'(imem_req_valid), 32'd0);
    check("flush_iv0", 32'(instr_valid), 32'd0);
    mem_hold = 1'b0;
    cycle();
    check("flush_noreq1", 32'(imem_req_valid), 32'd0);
    cycles(2);
    check("rd100_req_v", 32'(imem_req_valid), 32'd1);
    check("rd100_req_a", imem_req_addr, 32'h100);
    cycles(8);
    check("rd100_npop", 32'(popped.size() > pidx + 1), 32'd1);
    check("rd100_pc0", popped[pidx][63:32], 32'h100);
    check("rd100_ins0", popped[pidx][31:0], word_at(32'h100));
    check("rd100_pc1", popped[pidx+1][63:32], 32'h104);

    // Misaligned redirect with nothing in flight, best-case latency.
    instr_ready = 1'b0;
    cycles(8);
    do_redirect(32'h203);
    check("rd203_req_v", 32'(imem_req_valid), 32'd1);
    check("rd203_req_a", imem_req_addr, 32'h200);
    check("rd203_iv", 32'(instr_valid), 32'd0);
    instr_ready = 1'b1;
    cycle();
    check("rd203_lat1", 32'(instr_valid), 32'd0);
    cycle();
    w = word_at(32'h200);
    check("rd203_lat2", 32'(instr_valid), 32'd1);
    check("rd203_pc", instr_pc, 32'h200);
    check("rd203_ins", instr, w);
    check("rd203_opc", 32'(opcode), 32'(w[6:0]));
    check("rd203_f3", 32'(funct3), 32'(w[14:12]));
    check("rd203_f7", 32'(funct7), 32'(w[31:25]));

    // Address wrap.
    instr_ready = 1'b0;
    cycles(8);
    do_redirect(32'hFFFF_FFFE);
    check("wrap_req_a", imem_req_addr, 32'hFFFF_FFFC);
    ridx = reqs.size();
    pidx = popped.size();
    instr_ready = 1'b1;
    cycles(8);
    check("wrap_nreq", 32'(reqs.size() > ridx + 1), 32'd1);
    check("wrap_req0", reqs[ridx], 32'hFFFF_FFFC);
    check("wrap_req1", reqs[ridx+1], 32'h0);
    check("wrap_npop", 32'(popped.size() > pidx + 1), 32'd1);
    check("wrap_pc0", popped[pidx][63:32], 32'hFFFF_FFFC);
    check("wrap_pc1", popped[pidx+1][63:32], 32'h0);
    check("wrap_ins1", popped[pidx+1][31:0], word_at(32'h0));

    // Reset with a response pending.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem_rsp_valid) found = 1'b1;
      else cycle();
    end
    check("mrst_pend", 32'(found), 32'd1);
    rst = 1'b1;
    cycle();
    check_zero("mrst");
    rst = 1'b0;
    #1;
    check("mrst_req_v", 32'(imem_req_valid), 32'd1);
    check("mrst_req_a", imem_req_addr, 32'h0);
    check("mrst_iv", 32'(instr_valid), 32'd0);
    pidx = popped.size();
    cycles(6);
    check("mrst_npop", 32'(popped.size() > pidx + 1), 32'd1);
    check("mrst_pc0", popped[pidx][63:32], 32'h0);
    check("mrst_ins0", popped[pidx][31:0], word_at(32'h0));
    check("mrst_pc1", popped[pidx+1][63:32], 32'h4);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
